// File: rtl/alu_regfile_unit.sv
// alu_regfile_unit: 32 x XLEN integer register file (two combinational read
// ports, one synchronous write port, x0 hardwired to zero) alongside an
// independent combinational ALU (add / unsigned set-less-than).
// Optional feature: define REGFILE_BYPASS_EN for write-first read bypass.
module alu_regfile_unit #(
    parameter  int unsigned XLEN = 64,
    parameter  int unsigned NREG = 32,
    localparam int unsigned AW   = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [AW-1:0]   raddr1,
    output logic [XLEN-1:0] rdata1,
    input  logic [AW-1:0]   raddr2,
    output logic [XLEN-1:0] rdata2,
    input  logic            we,
    input  logic [AW-1:0]   waddr,
    input  logic [XLEN-1:0] wdata,
    input  logic [XLEN-1:0] src1,
    input  logic [XLEN-1:0] src2,
    input  logic [1:0]      aluop,
    output logic [XLEN-1:0] result
);

    // x0 has no storage; index 0 is never instantiated
    logic [XLEN-1:0] regs_q [1:NREG-1];
    logic [XLEN-1:0] regs_d [1:NREG-1];

    logic [XLEN-1:0] sum_c;
    logic            ltu_c;

    // Next-state of the register array: hold, or take wdata at waddr (x0 never matches)
    always_comb begin
        regs_d = regs_q;
        if (we) begin
            for (int i = 1; i < NREG; i++) begin
                if (waddr == AW'(i)) begin
                    regs_d[i] = wdata;
                end
            end
        end
    end

    // Storage update with synchronous clear; a write in a reset cycle is dropped
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 1; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            for (int i = 1; i < NREG; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    // Combinational read ports; address 0 (and any unpopulated address) reads zero
    always_comb begin
        rdata1 = '0;
        rdata2 = '0;
        for (int i = 1; i < NREG; i++) begin
            if (raddr1 == AW'(i)) begin
                rdata1 = regs_q[i];
            end
            if (raddr2 == AW'(i)) begin
                rdata2 = regs_q[i];
            end
        end
`ifdef REGFILE_BYPASS_EN
        // Write-first forwarding, suppressed during reset and for x0
        if (!rst && we && (waddr != '0)) begin
            if (raddr1 == waddr) begin
                rdata1 = wdata;
            end
            if (raddr2 == waddr) begin
                rdata2 = wdata;
            end
        end
`endif
    end

    // Stateless ALU; encoding 11 aliases add
    always_comb begin
        sum_c  = src1 + src2;
        ltu_c  = (src1 < src2);
        result = '0;
        case (aluop)
            2'b01, 2'b11: result = sum_c;
            2'b10:        result = XLEN'(ltu_c);
            default:      result = '0;
        endcase
    end

endmodule

// File: tb/tb_alu_regfile_unit.sv
// Scoreboard bench for alu_regfile_unit: the stimulus process pushes expected
// port values from an array/arithmetic reference model; a negedge monitor pops
// and compares them against the DUT.
module tb_alu_regfile_unit;

    localparam int unsigned XLEN = 64;

    logic            clk = 1'b0;
    logic            rst;
    logic [4:0]      raddr1, raddr2, waddr;
    logic [XLEN-1:0] rdata1, rdata2, wdata, src1, src2, result;
    logic            we;
    logic [1:0]      aluop;

    typedef struct {
        int              port;   // 0 rdata1, 1 rdata2, 2 result
        logic [XLEN-1:0] value;
        string           name;
    } exp_t;

    exp_t            exp_q[$];
    logic [XLEN-1:0] model [0:31];
    int              checks = 0;
    int              errors = 0;

    alu_regfile_unit dut (
        .clk    (clk),
        .rst    (rst),
        .raddr1 (raddr1),
        .rdata1 (rdata1),
        .raddr2 (raddr2),
        .rdata2 (rdata2),
        .we     (we),
        .waddr  (waddr),
        .wdata  (wdata),
        .src1   (src1),
        .src2   (src2),
        .aluop  (aluop),
        .result (result)
    );

    always #5 clk = ~clk;

    // Reference read: architectural value, plus write-first forwarding if enabled
    function automatic logic [XLEN-1:0] ref_read(input logic [4:0] a);
        if (a == 5'd0) return '0;
`ifdef REGFILE_BYPASS_EN
        if (!rst && we && waddr != 5'd0 && a == waddr) return wdata;
`endif
        return model[a];
    endfunction

    function automatic logic [XLEN-1:0] ref_alu(input logic [1:0] op,
                                                input logic [XLEN-1:0] a,
                                                input logic [XLEN-1:0] b);
        if (op == 2'b00) return '0;
        if (op == 2'b10) return (a < b) ? 64'd1 : 64'd0;
        return a + b;
    endfunction

    task automatic push(input int port, input logic [XLEN-1:0] v, input string nm);
        exp_t e;
        e.port = port; e.value = v; e.name = nm;
        exp_q.push_back(e);
    endtask

    task automatic set_in(input logic r, input logic w, input logic [4:0] wa,
                          input logic [XLEN-1:0] wd, input logic [4:0] a1,
                          input logic [4:0] a2, input logic [1:0] op,
                          input logic [XLEN-1:0] s1, input logic [XLEN-1:0] s2);
        rst = r; we = w; waddr = wa; wdata = wd;
        raddr1 = a1; raddr2 = a2; aluop = op; src1 = s1; src2 = s2;
    endtask

    task automatic push_model(input string tag);
        push(0, ref_read(raddr1), {tag, ".rdata1"});
        push(1, ref_read(raddr2), {tag, ".rdata2"});
        push(2, ref_alu(aluop, src1, src2), {tag, ".result"});
    endtask

    // Let the clock edge happen, then apply the architectural effect to the model
    task automatic advance();
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < 32; i++) model[i] = '0;
        end else if (we && waddr != 5'd0) begin
            model[waddr] = wdata;
        end
        #1;
    endtask

    // Monitor: outputs are stable mid-cycle, compare everything queued for this cycle
    always @(negedge clk) begin
        while (exp_q.size() > 0) begin
            exp_t e;
            logic [XLEN-1:0] act;
            e = exp_q.pop_front();
            case (e.port)
                0:       act = rdata1;
                1:       act = rdata2;
                default: act = result;
            endcase
            checks++;
            if (act !== e.value) begin
                errors++;
                $display("FAIL %s: got %h expected %h", e.name, act, e.value);
            end
        end
    end

    initial begin
        for (int i = 0; i < 32; i++) model[i] = '0;
        set_in(1'b1, 1'b0, 5'd0, '0, 5'd0, 5'd0, 2'b00, '0, '0);
        advance();

        // Reset-state reads
        set_in(1'b0, 1'b0, 5'd0, '0, 5'd1, 5'd31, 2'b00, 64'd3, 64'd4);
        push(0, 64'd0, "reset_state.rdata1");
        push(1, 64'd0, "reset_state.rdata2");
        push(2, 64'd0, "reset_state.result");
        advance();

        // Write x5, read it, then reset clears it
        set_in(1'b0, 1'b1, 5'd5, 64'hDEAD, 5'd1, 5'd2, 2'b01, 64'd1, 64'd2);
        push_model("wr_x5"); advance();
        set_in(1'b0, 1'b0, 5'd0, '0, 5'd5, 5'd5, 2'b00, '0, '0);
        push(0, 64'hDEAD, "rd_x5.rdata1"); push_model("rd_x5"); advance();
        set_in(1'b1, 1'b0, 5'd0, '0, 5'd5, 5'd31, 2'b00, '0, '0);
        push_model("in_reset"); advance();
        set_in(1'b0, 1'b0, 5'd0, '0, 5'd5, 5'd31, 2'b00, '0, '0);
        push(0, 64'd0, "after_reset.x5"); push(1, 64'd0, "after_reset.x31");
        advance();

        // Write x10 with same-cycle read, then read the new value
        set_in(1'b0, 1'b1, 5'd10, 64'h1234567887654321, 5'd10, 5'd10, 2'b00, '0, '0);
`ifdef REGFILE_BYPASS_EN
        push(0, 64'h1234567887654321, "same_cycle.x10");
`else
        push(0, 64'd0, "same_cycle.x10");
`endif
        push_model("same_cycle"); advance();
        set_in(1'b0, 1'b0, 5'd0, '0, 5'd10, 5'd0, 2'b00, '0, '0);
        push(0, 64'h1234567887654321, "next_cycle.x10"); push_model("next_cycle"); advance();

        // x0 is immutable
        set_in(1'b0, 1'b1, 5'd0, '1, 5'd0, 5'd0, 2'b00, '0, '0);
        push(0, 64'd0, "x0_wr.rdata1"); push(1, 64'd0, "x0_wr.rdata2"); advance();
        set_in(1'b0, 1'b0, 5'd0, '0, 5'd0, 5'd0, 2'b00, '0, '0);
        push(0, 64'd0, "x0_after.rdata1"); push(1, 64'd0, "x0_after.rdata2"); advance();

        // ALU boundary vectors
        set_in(1'b0, 1'b0, 5'd0, '0, 5'd0, 5'd0, 2'b01, '1, 64'd1);
        push(2, 64'd0, "add_wrap"); advance();
        set_in(1'b0, 1'b0, 5'd0, '0, 5'd0, 5'd0, 2'b11, 64'h80000000, 64'hFFFF_FFFF_FFFF_FFFC);
        push(2, 64'h7FFFFFFC, "add_op11"); advance();
        set_in(1'b0, 1'b0, 5'd0, '0, 5'd0, 5'd0, 2'b10, 64'd1, '1);
        push(2, 64'd1, "sltu_lt"); advance();
        set_in(1'b0, 1'b0, 5'd0, '0, 5'd0, 5'd0, 2'b10, '1, 64'd1);
        push(2, 64'd0, "sltu_gt"); advance();
        set_in(1'b0, 1'b0, 5'd0, '0, 5'd0, 5'd0, 2'b10, 64'd5, 64'd5);
        push(2, 64'd0, "sltu_eq"); advance();

        // Write ignored during reset; op 00 yields zero
        set_in(1'b0, 1'b1, 5'd3, 64'd99, 5'd3, 5'd3, 2'b00, '0, '0);
        push_model("wr_x3"); advance();
        set_in(1'b1, 1'b1, 5'd3, 64'd7, 5'd3, 5'd3, 2'b00, '1, '1);
        push(2, 64'd0, "op00"); push_model("rst_wr_x3"); advance();
        set_in(1'b0, 1'b0, 5'd0, '0, 5'd3, 5'd3, 2'b00, 64'h55, 64'hAA);
        push(0, 64'd0, "rst_wr_ignored.x3"); push(2, 64'd0, "op00_b"); advance();

        // Randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            logic [4:0]      wa, a1, a2;
            logic [XLEN-1:0] s1, s2;
            wa = 5'($urandom_range(0, 31));
            a1 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
            a2 = ($urandom_range(0, 3) == 0) ? a1 : 5'($urandom_range(0, 31));
            s1 = {$urandom, $urandom};
            s2 = ($urandom_range(0, 7) == 0) ? s1 : {$urandom, $urandom};
            if ($urandom_range(0, 3) == 0) s2 = s1 ^ 64'(1 << $urandom_range(0, 31));
            set_in(($urandom_range(0, 39) == 0), 1'($urandom_range(0, 1)), wa,
                   {$urandom, $urandom}, a1, a2, 2'($urandom_range(0, 3)), s1, s2);
            push_model("rand");
            advance();
        end

        // Bounded drain of anything still queued
        for (int t = 0; t < 4 && exp_q.size() > 0; t++) @(negedge clk);
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
